// File: rtl/ddr4_cmd_timing_monitor_if.sv
// rtl/ddr4_cmd_timing_monitor_if.sv - command bus and violation report bundle for the DDR4 timing monitor
//
// Purpose: groups the controller-to-DRAM command signals and the monitor's
// violation report into one bundle.
//   master : drives cmd_valid/cmd_code/cmd_bank, observes the report
//   slave  : the monitor; observes commands, drives viol_* and bank_open
// Signals:
//   cmd_valid  - command present this cycle
//   cmd_code   - 0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 REF, 6/7 illegal
//   cmd_bank   - target bank (ignored for NOP/REF)
//   viol_valid - one-cycle pulse, previous command violated a rule
//   viol_code  - violation bitmask of that command
//   viol_bank  - bank of that command (0 for REF)
//   viol_count - saturating count of violating commands
//   bank_open  - per-bank open-row flag
interface ddr4_cmd_timing_monitor_if #(
  parameter int NUM_BANKS = 4
) ();
  localparam int BW = $clog2(NUM_BANKS);

  logic                 cmd_valid;
  logic [2:0]           cmd_code;
  logic [BW-1:0]        cmd_bank;
  logic                 viol_valid;
  logic [7:0]           viol_code;
  logic [BW-1:0]        viol_bank;
  logic [15:0]          viol_count;
  logic [NUM_BANKS-1:0] bank_open;

  modport master (
    output cmd_valid, cmd_code, cmd_bank,
    input  viol_valid, viol_code, viol_bank, viol_count, bank_open
  );

  modport slave (
    input  cmd_valid, cmd_code, cmd_bank,
    output viol_valid, viol_code, viol_bank, viol_count, bank_open
  );
endinterface

// File: rtl/ddr4_cmd_timing_monitor.sv
// rtl/ddr4_cmd_timing_monitor.sv - passive DDR4 command timing and bank-state checker
//
// Purpose: watches the command bus, keeps per-bank open state and elapsed
// cycle counters since ACT/PRE (per bank) and RD/WR/REF (global), and reports
// every command that breaks a timing minimum or is issued in an illegal bank
// state. State always follows the command as the DRAM would see it, even when
// that command was flagged.
// Ports:
//   clock   - rising-edge clock
//   Reset_n - asynchronous active-low reset
//   bus     - slave side of ddr4_cmd_timing_monitor_if (commands in, report out)
module ddr4_cmd_timing_monitor #(
  parameter int NUM_BANKS = 4,
  parameter int T_RCD     = 16,
  parameter int T_RP      = 16,
  parameter int T_RAS     = 39,
  parameter int T_CCD     = 4,
  parameter int T_RFC     = 350,
  parameter int CNT_W     = 10
) (
  input logic                      clock,
  input logic                      Reset_n,
  ddr4_cmd_timing_monitor_if.slave bus
);
  localparam int BW = $clog2(NUM_BANKS);

  localparam logic [2:0] NOP = 3'd0;
  localparam logic [2:0] ACT = 3'd1;
  localparam logic [2:0] RD  = 3'd2;
  localparam logic [2:0] WR  = 3'd3;
  localparam logic [2:0] PRE = 3'd4;
  localparam logic [2:0] REF = 3'd5;

  localparam logic [CNT_W-1:0] SAT     = '1;
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] LIM_RCD = CNT_W'(T_RCD);
  localparam logic [CNT_W-1:0] LIM_RP  = CNT_W'(T_RP);
  localparam logic [CNT_W-1:0] LIM_RAS = CNT_W'(T_RAS);
  localparam logic [CNT_W-1:0] LIM_CCD = CNT_W'(T_CCD);
  localparam logic [CNT_W-1:0] LIM_RFC = CNT_W'(T_RFC);

  logic [CNT_W-1:0]     e_act [NUM_BANKS];
  logic [CNT_W-1:0]     e_pre [NUM_BANKS];
  logic [CNT_W-1:0]     e_cas;
  logic [CNT_W-1:0]     e_ref;
  logic [NUM_BANKS-1:0] open_q;

  logic                 viol_valid_q;
  logic [7:0]           viol_code_q;
  logic [BW-1:0]        viol_bank_q;
  logic [15:0]          viol_count_q;

  logic                 live;
  logic                 legal;
  logic [BW-1:0]        bank;
  logic [2:0]           code;
  logic [7:0]           v;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x == SAT) ? SAT : x + ONE;
  endfunction

  assign code  = bus.cmd_code;
  assign bank  = bus.cmd_bank;
  assign live  = bus.cmd_valid && (code != NOP);
  assign legal = (code >= ACT) && (code <= REF);

  always_comb begin
    v = 8'h00;
    if (live) begin
      case (code)
        ACT: begin
          if (open_q[bank])          v[5] = 1'b1;
          if (e_pre[bank] < LIM_RP)  v[1] = 1'b1;
        end
        RD, WR: begin
          if (!open_q[bank])         v[5] = 1'b1;
          if (e_act[bank] < LIM_RCD) v[0] = 1'b1;
          if (e_cas < LIM_CCD)       v[3] = 1'b1;
        end
        PRE: begin
          if (e_act[bank] < LIM_RAS) v[2] = 1'b1;
        end
        REF: begin
          if (|open_q)               v[5] = 1'b1;
        end
        default: v[6] = 1'b1;
      endcase
      // Refresh recovery applies to every real command; illegal codes only get bit 6.
      if (legal && (e_ref < LIM_RFC)) v[4] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        e_act[i] <= SAT;
        e_pre[i] <= SAT;
      end
      e_cas        <= SAT;
      e_ref        <= SAT;
      open_q       <= '0;
      viol_valid_q <= 1'b0;
      viol_code_q  <= 8'h00;
      viol_bank_q  <= '0;
      viol_count_q <= 16'h0000;
    end else begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        if (live && (code == ACT) && (bank == BW'(i))) begin
          e_act[i]  <= ONE;
          open_q[i] <= 1'b1;
        end else begin
          e_act[i]  <= sat_inc(e_act[i]);
        end
        // PRE to a closed bank is a no-op: E_pre keeps counting from the real precharge.
        if (live && (code == PRE) && (bank == BW'(i)) && open_q[i]) begin
          e_pre[i]  <= ONE;
          open_q[i] <= 1'b0;
        end else begin
          e_pre[i]  <= sat_inc(e_pre[i]);
        end
      end
      e_cas <= (live && ((code == RD) || (code == WR))) ? ONE : sat_inc(e_cas);
      e_ref <= (live && (code == REF)) ? ONE : sat_inc(e_ref);

      viol_valid_q <= |v;
      viol_code_q  <= v;
      viol_bank_q  <= ((|v) && (code != REF)) ? bank : '0;
      if ((|v) && (viol_count_q != 16'hFFFF)) viol_count_q <= viol_count_q + 16'h0001;
    end
  end

  assign bus.viol_valid = viol_valid_q;
  assign bus.viol_code  = viol_code_q;
  assign bus.viol_bank  = viol_bank_q;
  assign bus.viol_count = viol_count_q;
  assign bus.bank_open  = open_q;
endmodule
